// File: rtl/flag_update_ctrl_pkg.sv
// Shared definitions for the P flag update controller: bit indices, op codes,
// writable mask, flag write payload and the entry-sequence state type.
package flag_update_ctrl_pkg;

   localparam int unsigned FLAG_W = 8;

   localparam int unsigned BIT_C = 0;
   localparam int unsigned BIT_Z = 1;
   localparam int unsigned BIT_I = 2;
   localparam int unsigned BIT_D = 3;
   localparam int unsigned BIT_B = 4;
   localparam int unsigned BIT_U = 5;
   localparam int unsigned BIT_V = 6;
   localparam int unsigned BIT_N = 7;

   localparam logic [FLAG_W-1:0] MASK_C = FLAG_W'(1) << BIT_C;
   localparam logic [FLAG_W-1:0] MASK_I = FLAG_W'(1) << BIT_I;
   localparam logic [FLAG_W-1:0] MASK_D = FLAG_W'(1) << BIT_D;
   localparam logic [FLAG_W-1:0] MASK_B = FLAG_W'(1) << BIT_B;
   localparam logic [FLAG_W-1:0] MASK_U = FLAG_W'(1) << BIT_U;
   localparam logic [FLAG_W-1:0] MASK_V = FLAG_W'(1) << BIT_V;

   // B and U are not physical flag bits, so they are never write-enabled
   localparam logic [FLAG_W-1:0] WRITABLE_MASK = 8'hCF;

   localparam logic [2:0] OP_CLC  = 3'd0;
   localparam logic [2:0] OP_SEC  = 3'd1;
   localparam logic [2:0] OP_CLI  = 3'd2;
   localparam logic [2:0] OP_SEI  = 3'd3;
   localparam logic [2:0] OP_CLD  = 3'd4;
   localparam logic [2:0] OP_SED  = 3'd5;
   localparam logic [2:0] OP_CLV  = 3'd6;
   localparam logic [2:0] OP_NONE = 3'd7;

   typedef struct packed {
      logic [FLAG_W-1:0] ena;
      logic [FLAG_W-1:0] d;
   } flag_wr_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PUSH = 2'd1,
      ST_SETI = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic flag_wr_t op_write(input logic [2:0] code);
      flag_wr_t w;
      w = '0;
      case (code)
         OP_CLC: w.ena = MASK_C;
         OP_SEC: begin w.ena = MASK_C; w.d = MASK_C; end
         OP_CLI: w.ena = MASK_I;
         OP_SEI: begin w.ena = MASK_I; w.d = MASK_I; end
         OP_CLD: w.ena = MASK_D;
         OP_SED: begin w.ena = MASK_D; w.d = MASK_D; end
         OP_CLV: w.ena = MASK_V;
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/flag_update_ctrl_skid.sv
// One-deep holding register for an ALU flag update that lost arbitration.
module flag_skid_buffer
   import flag_update_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              drain,
   input  logic [FLAG_W-1:0] mask_in,
   input  logic [FLAG_W-1:0] flags_in,
   output logic              full,
   output logic [FLAG_W-1:0] mask,
   output logic [FLAG_W-1:0] flags
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         full  <= 1'b0;
         mask  <= '0;
         flags <= '0;
      end else if (load) begin
         full  <= 1'b1;
         mask  <= mask_in;
         flags <= flags_in;
      end else if (drain) begin
         full  <= 1'b0;
      end
   end

endmodule

// File: rtl/flag_update_ctrl.sv
// P flag register write sequencer: pull/op/ALU arbitration plus interrupt/BRK entry.
// Build option: CMOS_DCLEAR_EN makes the entry sequence also clear D (65C02).
module flag_update_ctrl
   import flag_update_ctrl_pkg::*;
#(
   parameter int unsigned PUSH_TIMEOUT = 16,
   parameter bit          ENTRY_SET_I  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] p_q,
   input  logic       alu_valid,
   input  logic [7:0] alu_mask,
   input  logic [7:0] alu_flags,
   input  logic       op_valid,
   input  logic [2:0] op_code,
   input  logic       pull_valid,
   input  logic [7:0] pull_data,
   input  logic       int_req,
   input  logic       brk_req,
   input  logic       push_ack,
   output logic [7:0] flag_ena,
   output logic [7:0] flag_d,
   output logic       push_valid,
   output logic [7:0] push_data,
   output logic       alu_stall,
   output logic       busy,
   output logic       int_done,
   output logic       push_err
);

   localparam int unsigned CNT_W = 8;

`ifdef CMOS_DCLEAR_EN
   localparam logic [FLAG_W-1:0] SETI_ENA = MASK_I | MASK_D;
`else
   localparam logic [FLAG_W-1:0] SETI_ENA = MASK_I;
`endif

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   flag_wr_t          wr_nx;
   logic              push_valid_nx, int_done_nx, push_err_nx;
   logic [FLAG_W-1:0] push_data_nx;
   logic              entry_req, op_req, alu_win;
   logic              skid_full, skid_load, skid_drain;
   logic [FLAG_W-1:0] skid_mask, skid_flags;

   assign entry_req = int_req | brk_req;
   // op_code NONE is not a request: it neither writes nor blocks the skid
   assign op_req    = op_valid && (op_code != OP_NONE);
   assign alu_stall = skid_full;

   flag_skid_buffer u_skid (
      .clk      (clk),
      .reset    (reset),
      .load     (skid_load),
      .drain    (skid_drain),
      .mask_in  (alu_mask),
      .flags_in (alu_flags),
      .full     (skid_full),
      .mask     (skid_mask),
      .flags    (skid_flags)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Arbitration and entry sequencing; outputs describe the cycle being entered
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      wr_nx         = '0;
      push_valid_nx = push_valid;
      push_data_nx  = push_data;
      int_done_nx   = 1'b0;
      push_err_nx   = 1'b0;
      alu_win       = 1'b0;
      skid_drain    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (entry_req) begin
               state_nx      = ST_PUSH;
               cnt_nx        = '0;
               push_valid_nx = 1'b1;
               push_data_nx  = ((p_q | MASK_U) & ~MASK_B) | (brk_req ? MASK_B : '0);
            end else if (pull_valid) begin
               wr_nx = '{ena: WRITABLE_MASK, d: pull_data};
            end else if (op_req) begin
               wr_nx = op_write(op_code);
            end else if (skid_full) begin
               wr_nx      = '{ena: skid_mask & WRITABLE_MASK, d: skid_flags};
               skid_drain = 1'b1;
            end else if (alu_valid) begin
               wr_nx   = '{ena: alu_mask & WRITABLE_MASK, d: alu_flags};
               alu_win = 1'b1;
            end
         end
         ST_PUSH: begin
            if (push_ack || (cnt == CNT_W'(PUSH_TIMEOUT - 1))) begin
               push_err_nx   = !push_ack;
               push_valid_nx = 1'b0;
               push_data_nx  = '0;
               if (ENTRY_SET_I) begin
                  state_nx = ST_SETI;
                  wr_nx    = '{ena: SETI_ENA, d: MASK_I};
               end else begin
                  state_nx    = ST_DONE;
                  int_done_nx = 1'b1;
               end
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         ST_SETI: begin
            state_nx    = ST_DONE;
            int_done_nx = 1'b1;
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase

      skid_load = alu_valid && !skid_full && !alu_win;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         flag_ena   <= '0;
         flag_d     <= '0;
         push_valid <= 1'b0;
         push_data  <= '0;
         busy       <= 1'b0;
         int_done   <= 1'b0;
         push_err   <= 1'b0;
      end else begin
         flag_ena   <= wr_nx.ena;
         flag_d     <= wr_nx.d;
         push_valid <= push_valid_nx;
         push_data  <= push_data_nx;
         busy       <= (state_nx != ST_IDLE);
         int_done   <= int_done_nx;
         push_err   <= push_err_nx;
      end
   end

endmodule

// File: tb/tb_flag_update_ctrl.sv
// Bench for flag_update_ctrl: directed scenarios then random traffic against a
// transaction-level model; also exercises the CMOS_DCLEAR_EN build when defined.
module tb_flag_update_ctrl;

   localparam int unsigned PT = 16;
`ifdef CMOS_DCLEAR_EN
   localparam logic [7:0] SETI_ENA_EXP = 8'h0C;
`else
   localparam logic [7:0] SETI_ENA_EXP = 8'h04;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] p_q;
   logic       alu_valid, op_valid, pull_valid, int_req, brk_req, push_ack;
   logic [7:0] alu_mask, alu_flags, pull_data;
   logic [2:0] op_code;
   logic [7:0] flag_ena, flag_d, push_data;
   logic       push_valid, alu_stall, busy, int_done, push_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   flag_update_ctrl #(.PUSH_TIMEOUT(PT), .ENTRY_SET_I(1'b1)) dut (
      .clk(clk), .reset(reset), .p_q(p_q),
      .alu_valid(alu_valid), .alu_mask(alu_mask), .alu_flags(alu_flags),
      .op_valid(op_valid), .op_code(op_code),
      .pull_valid(pull_valid), .pull_data(pull_data),
      .int_req(int_req), .brk_req(brk_req), .push_ack(push_ack),
      .flag_ena(flag_ena), .flag_d(flag_d),
      .push_valid(push_valid), .push_data(push_data),
      .alu_stall(alu_stall), .busy(busy), .int_done(int_done), .push_err(push_err)
   );

   // Model: entry = a push phase of unknown length followed by a fixed tail of
   // cycles (1 = set-I write, 2 = completion pulse); ALU backlog is a queue.
   bit          m_in_push;
   int          m_wait;
   logic [7:0]  m_pbyte;
   int          m_tail[$];
   logic [15:0] m_skid[$];
   logic [7:0]  m_p, m_ena, m_d;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_in();
      alu_valid = 0; alu_mask = '0; alu_flags = '0;
      op_valid = 0; op_code = 3'd7;
      pull_valid = 0; pull_data = '0;
      int_req = 0; brk_req = 0; push_ack = 0;
   endtask

   task automatic step();
      logic [7:0] e_ena, e_d, e_pd;
      bit e_pv, e_done, e_err, e_busy, stall, idle, taken;
      int idx;
      e_ena = '0; e_d = '0; e_pd = '0;
      e_pv = 0; e_done = 0; e_err = 0; e_busy = 0; taken = 0;
      if (!reset) begin
         m_in_push = 0; m_wait = 0; m_tail.delete(); m_skid.delete();
      end else begin
         stall = (m_skid.size() != 0);
         idle  = !m_in_push && (m_tail.size() == 0);
         if (idle) begin
            if (int_req || brk_req) begin
               m_in_push = 1; m_wait = 0;
               m_pbyte = (m_p | 8'h20) & 8'hEF;
               if (brk_req) m_pbyte = m_pbyte | 8'h10;
            end else if (pull_valid) begin
               e_ena = 8'hCF; e_d = pull_data;
            end else if (op_valid && op_code != 3'd7) begin
               idx = (op_code <= 1) ? 0 : (op_code <= 3) ? 2 : (op_code <= 5) ? 3 : 6;
               e_ena = 8'(1 << idx);
               e_d = op_code[0] ? e_ena : 8'h00;
            end else if (stall) begin
               e_ena = m_skid[0][15:8] & 8'hCF; e_d = m_skid[0][7:0];
               void'(m_skid.pop_front());
            end else if (alu_valid) begin
               e_ena = alu_mask & 8'hCF; e_d = alu_flags; taken = 1;
            end
         end else if (m_in_push) begin
            if (push_ack || m_wait == PT - 1) begin
               m_in_push = 0; e_err = !push_ack;
               m_tail.push_back(1); m_tail.push_back(2);
            end else m_wait++;
         end else begin
            void'(m_tail.pop_front());
         end
         if (alu_valid && !stall && !taken) m_skid.push_back({alu_mask, alu_flags});
         e_pv = m_in_push;
         e_pd = m_in_push ? m_pbyte : 8'h00;
         if (m_tail.size() != 0 && m_tail[0] == 1) begin e_ena = SETI_ENA_EXP; e_d = 8'h04; end
         e_done = (m_tail.size() != 0 && m_tail[0] == 2);
         e_busy = m_in_push || (m_tail.size() != 0);
      end
      // external flag register commits this cycle's expected write at the edge
      m_p = (m_p & ~m_ena) | (m_d & m_ena);
      m_ena = e_ena; m_d = e_d;
      @(posedge clk); #1;
      chk("flag_ena", flag_ena, e_ena);
      chk("flag_d", flag_d & flag_ena, e_d & e_ena);
      chk("push_valid", 8'(push_valid), 8'(e_pv));
      chk("push_data", push_data, e_pd);
      chk("busy", 8'(busy), 8'(e_busy));
      chk("int_done", 8'(int_done), 8'(e_done));
      chk("push_err", 8'(push_err), 8'(e_err));
      chk("alu_stall", 8'(alu_stall), 8'(m_skid.size() != 0));
      p_q = m_p;
   endtask

   initial begin
      clear_in();
      reset = 0;
      m_p = 8'h5A; p_q = m_p; m_ena = '0; m_d = '0;
      repeat (3) step();
      reset = 1;
      step();

      // SEC
      op_valid = 1; op_code = 3'd1; step();
      clear_in(); step(); step();

      // pull and ALU collide: ALU goes through the skid
      pull_valid = 1; pull_data = 8'hFF; alu_valid = 1; alu_mask = 8'h82; alu_flags = 8'h80;
      step();
      clear_in(); step(); step();

      // BRK with p=01, ack after 3 cycles
      m_p = 8'h01; p_q = m_p; step();
      brk_req = 1; step();
      clear_in(); step(); step();
      push_ack = 1; step();
      clear_in(); repeat (3) step();

      // IRQ with no ack: timeout
      int_req = 1; step();
      clear_in(); repeat (PT + 4) step();

      // ALU during busy, then again while stalled
      int_req = 1; step();
      clear_in(); alu_valid = 1; alu_mask = 8'h03; alu_flags = 8'h01; step();
      alu_mask = 8'hC0; alu_flags = 8'hC0; step();
      clear_in(); step();
      push_ack = 1; step();
      clear_in(); repeat (4) step();

      // reset in the middle of a push
      int_req = 1; step();
      clear_in(); step();
      reset = 0; step();
      reset = 1; repeat (2) step();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         clear_in();
         reset      = ($urandom_range(0, 199) != 0);
         alu_valid  = ($urandom_range(0, 9) < 4);
         alu_mask   = 8'($urandom); alu_flags = 8'($urandom);
         op_valid   = ($urandom_range(0, 9) < 2);
         op_code    = 3'($urandom);
         pull_valid = ($urandom_range(0, 9) == 0);
         pull_data  = 8'($urandom);
         int_req    = ($urandom_range(0, 39) == 0);
         brk_req    = ($urandom_range(0, 59) == 0);
         push_ack   = ($urandom_range(0, 9) < 2);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
